// File: rtl/polyphase_pkg.sv
// Shared types and elaboration-time helpers for the polyphase decimator controller.
//   state_e   : controller FSM encoding (load / wait / sum / out)
//   clog2     : ceil(log2(v)) usable in parameter and port-width expressions
//   sum_width : output width needed to sum 'phases' terms of 'word_w' bits without overflow
package polyphase_pkg;

    typedef enum logic [1:0] {
        StLoad,
        StWait,
        StSum,
        StOut
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned sum_width(input int unsigned word_w,
                                              input int unsigned phases);
        return word_w + clog2(phases);
    endfunction

endpackage

// File: rtl/pp_seq_accum.sv
// Sequential sign-extending accumulator over the packed sub-filter outputs.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : zero the accumulator
//   add_i         : acc += sign_ext(ph_y_i[sel_i])
//   sel_i         : phase whose output is the current term
//   ph_y_i        : packed sub-filter outputs, phase p at [p*WordW +: WordW]
//   sum_o         : acc + current term (combinational), used for the final term
module pp_seq_accum
    import polyphase_pkg::*;
#(
    parameter int unsigned NumPhases = 4,
    parameter int unsigned WordW     = 20,
    parameter int unsigned SumW      = 22
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       add_i,
    input  logic [clog2(NumPhases)-1:0] sel_i,
    input  logic [NumPhases*WordW-1:0] ph_y_i,
    output logic [SumW-1:0]            sum_o
);

    logic [SumW-1:0]  acc_q;
    logic [WordW-1:0] term;
    logic [SumW-1:0]  term_ext;

    assign term     = ph_y_i[sel_i*WordW +: WordW];
    assign term_ext = {{(SumW-WordW){term[WordW-1]}}, term};
    assign sum_o    = acc_q + term_ext;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (add_i) begin
            acc_q <= sum_o;
        end
    end

endmodule

// File: rtl/polyphase_dec_ctrl.sv
// Sequencing controller for an M-phase polyphase decimator.
// Commutates input samples to sub-filters NUM_PHASES-1 down to 0, waits for the
// sub-filters to settle, sums their outputs one per cycle and presents one
// decimated sample per frame on a valid/ready output.
//   clk, reset          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake, in_data the input sample
//   ph_x, ph_en         : shared sub-filter data bus and one-hot single-cycle enable
//   ph_y                : packed sub-filter outputs
//   out_valid/out_ready : output handshake, out_data the decimated sample
module polyphase_dec_ctrl
    import polyphase_pkg::*;
#(
    parameter  int unsigned NUM_PHASES    = 4,
    parameter  int unsigned word_size_in  = 8,
    parameter  int unsigned word_size_out = 20,
    parameter  int unsigned SUB_LAT       = 2,
    localparam int unsigned SUM_W         = sum_width(word_size_out, NUM_PHASES)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [word_size_in-1:0]             in_data,
    output logic [word_size_in-1:0]             ph_x,
    output logic [NUM_PHASES-1:0]               ph_en,
    input  logic [NUM_PHASES*word_size_out-1:0] ph_y,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [SUM_W-1:0]                    out_data
);

    localparam int unsigned PhW   = clog2(NUM_PHASES);
    localparam int unsigned WaitW = clog2(SUB_LAT + 2);

    localparam logic [PhW-1:0]        PhMax    = PhW'(NUM_PHASES - 1);
    localparam logic [WaitW-1:0]      WaitInit = WaitW'(SUB_LAT + 1);
    localparam logic [NUM_PHASES-1:0] OneHot0  = NUM_PHASES'(1);

    state_e                  state_q;
    logic [PhW-1:0]          phase_q;
    logic [PhW-1:0]          idx_q;
    logic [WaitW-1:0]        wait_q;
    logic [word_size_in-1:0] ph_x_q;
    logic [NUM_PHASES-1:0]   ph_en_q;
    logic                    out_valid_q;
    logic [SUM_W-1:0]        out_data_q;

    logic             acc_clr;
    logic             acc_add;
    logic [SUM_W-1:0] acc_sum;

    // Gated with reset so in_ready is low while reset is held and high on the
    // very first cycle after release.
    assign in_ready = reset & (state_q == StLoad);

    // Accumulator is cleared on the edge entering SUM; the last term goes
    // straight into out_data instead of the accumulator.
    assign acc_clr = (state_q == StWait) && (wait_q == '0);
    assign acc_add = (state_q == StSum) && (idx_q != PhMax);

    pp_seq_accum #(
        .NumPhases (NUM_PHASES),
        .WordW     (word_size_out),
        .SumW      (SUM_W)
    ) u_accum (
        .clk_i  (clk),
        .rst_ni (reset),
        .clr_i  (acc_clr),
        .add_i  (acc_add),
        .sel_i  (idx_q),
        .ph_y_i (ph_y),
        .sum_o  (acc_sum)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StLoad;
            phase_q     <= PhMax;
            idx_q       <= '0;
            wait_q      <= '0;
            ph_x_q      <= '0;
            ph_en_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            ph_en_q <= '0;
            unique case (state_q)
                StLoad: begin
                    if (in_valid) begin
                        ph_x_q  <= in_data;
                        ph_en_q <= OneHot0 << phase_q;
                        if (phase_q == '0) begin
                            phase_q <= PhMax;
                            wait_q  <= WaitInit;
                            state_q <= StWait;
                        end else begin
                            phase_q <= phase_q - 1'b1;
                        end
                    end
                end
                // Spans the final ph_en cycle plus SUB_LAT+1 settle cycles.
                StWait: begin
                    if (wait_q == '0) begin
                        idx_q   <= '0;
                        state_q <= StSum;
                    end else begin
                        wait_q <= wait_q - 1'b1;
                    end
                end
                StSum: begin
                    if (idx_q == PhMax) begin
                        out_data_q  <= acc_sum;
                        out_valid_q <= 1'b1;
                        state_q     <= StOut;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StLoad;
                    end
                end
            endcase
        end
    end

    assign ph_x      = ph_x_q;
    assign ph_en     = ph_en_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
